// File: rtl/calc_exec_ctrl.sv
// Five-cycle execution controller for the 4-entry calculator register file.
// Define CALC_MUL_EN to make opcode 4'hA a 16x16 multiply; otherwise it is illegal.
module calc_exec_ctrl #(
  parameter int W         = 16,
  parameter int NREG_BITS = 2
) (
  input  logic                 ck,
  input  logic                 res,
  input  logic [15:0]          inst,
  input  logic                 inst_valid,
  output logic                 inst_ready,
  input  logic [W-1:0]         q,
  output logic [NREG_BITS-1:0] rsel,
  output logic [W-1:0]         d,
  output logic [NREG_BITS-1:0] wsel,
  output logic                 we,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal,
  output logic                 zf,
  output logic                 cf
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t               state_q;
  logic [15:0]          inst_q;
  logic [W-1:0]         op_a_q;
  logic [W-1:0]         op_b_q;
  logic [W-1:0]         result_q;
  logic [NREG_BITS-1:0] rsel_q;
  logic [NREG_BITS-1:0] wsel_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 we_q;
  logic                 done_q;
  logic                 illegal_q;
  logic                 zf_q;
  logic                 cf_q;

  logic [3:0]           opc_s;
  logic [W:0]           sum_s;
  logic [W-1:0]         alu_d;
  logic                 wr_d;
  logic                 ill_d;
  logic                 upd_s;
  logic                 zf_d;
  logic                 cf_d;

  assign opc_s = inst_q[15:12];
  assign sum_s = {1'b0, op_a_q} + {1'b0, op_b_q};

`ifdef CALC_MUL_EN
  logic [2*W-1:0] prod_s;
  assign prod_s = op_a_q * op_b_q;
`endif

  // ALU: result, write/illegal qualifiers and next flag values for the latched opcode
  always_comb begin
    alu_d = '0;
    wr_d  = 1'b0;
    ill_d = 1'b0;
    upd_s = 1'b0;
    cf_d  = cf_q;
    case (opc_s)
      4'h0: begin
        alu_d = '0;
      end
      4'h1: begin
        alu_d = {{(W-8){1'b0}}, inst_q[7:0]};
        wr_d  = 1'b1;
      end
      4'h2: begin
        alu_d = op_a_q;
        wr_d  = 1'b1;
      end
      4'h3: begin
        alu_d = sum_s[W-1:0];
        cf_d  = sum_s[W];
        wr_d  = 1'b1;
        upd_s = 1'b1;
      end
      4'h4: begin
        alu_d = op_a_q - op_b_q;
        cf_d  = (op_a_q < op_b_q);
        wr_d  = 1'b1;
        upd_s = 1'b1;
      end
      4'h5: begin
        alu_d = op_a_q & op_b_q;
        cf_d  = 1'b0;
        wr_d  = 1'b1;
        upd_s = 1'b1;
      end
      4'h6: begin
        alu_d = op_a_q | op_b_q;
        cf_d  = 1'b0;
        wr_d  = 1'b1;
        upd_s = 1'b1;
      end
      4'h7: begin
        alu_d = op_a_q ^ op_b_q;
        cf_d  = 1'b0;
        wr_d  = 1'b1;
        upd_s = 1'b1;
      end
      4'h8: begin
        alu_d = {op_a_q[W-2:0], 1'b0};
        cf_d  = op_a_q[W-1];
        wr_d  = 1'b1;
        upd_s = 1'b1;
      end
      4'h9: begin
        alu_d = {1'b0, op_a_q[W-1:1]};
        cf_d  = op_a_q[0];
        wr_d  = 1'b1;
        upd_s = 1'b1;
      end
`ifdef CALC_MUL_EN
      4'hA: begin
        alu_d = prod_s[W-1:0];
        cf_d  = |prod_s[2*W-1:W];
        wr_d  = 1'b1;
        upd_s = 1'b1;
      end
`endif
      default: begin
        alu_d = '0;
        ill_d = 1'b1;
      end
    endcase
    if (upd_s) begin
      zf_d = (alu_d == '0);
    end else begin
      zf_d = zf_q;
    end
  end

  // Sequencer: walks IDLE->RD_A->RD_B->EXEC->WB and registers every output for the next state
  always_ff @(posedge ck) begin
    if (res) begin
      state_q   <= S_IDLE;
      inst_q    <= 16'h0000;
      op_a_q    <= '0;
      op_b_q    <= '0;
      result_q  <= '0;
      rsel_q    <= '0;
      wsel_q    <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      zf_q      <= 1'b0;
      cf_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (inst_valid) begin
            inst_q  <= inst;
            rsel_q  <= inst[9:8];
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RD_A;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RD_A: begin
          op_a_q  <= q;
          rsel_q  <= inst_q[7:6];
          state_q <= S_RD_B;
        end
        S_RD_B: begin
          op_b_q  <= q;
          rsel_q  <= '0;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          result_q  <= alu_d;
          wsel_q    <= inst_q[11:10];
          we_q      <= wr_d;
          done_q    <= 1'b1;
          illegal_q <= ill_d;
          zf_q      <= zf_d;
          cf_q      <= cf_d;
          state_q   <= S_WB;
        end
        S_WB: begin
          result_q  <= '0;
          wsel_q    <= '0;
          we_q      <= 1'b0;
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          rsel_q    <= '0;
          wsel_q    <= '0;
          result_q  <= '0;
          we_q      <= 1'b0;
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  // A reset arriving during WB must suppress the pending write and completion strobes
  assign we         = we_q & ~res;
  assign done       = done_q & ~res;
  assign illegal    = illegal_q & ~res;
  assign inst_ready = ready_q;
  assign busy       = busy_q;
  assign rsel       = rsel_q;
  assign wsel       = wsel_q;
  assign d          = result_q;
  assign zf         = zf_q;
  assign cf         = cf_q;

endmodule
